// File: rtl/updi_rx_framer.sv
// UPDI line receiver: oversamples rxd, recovers 8E2 frames and writes one 12-bit status
// word per frame into a word memory through a csb0/web0/addr0 port.
module updi_rx_framer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned ADDR_W       = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_n,
  input  logic              rxd,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [11:0]       o_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full
);

  localparam int unsigned CntW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam int unsigned MemWords  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LastCount = (ADDR_W + 1)'(MemWords - 1);

  typedef enum logic [3:0] {
    StIdle, StHunt, StStart, StData, StParity, StStop1, StStop2, StWrite, StBrkWait, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic                rxs;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          data_q, data_d;
  logic                par_q, par_d;
  logic                s1_q, s1_d;
  logic                csb0_q, csb0_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [11:0]         odata_q, odata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                perr, ferr, brk;

  assign rxs = sync_q[1];

  // Status bits for the frame being closed; rxs is the second stop bit at that sample.
  assign perr = ^data_q ^ par_q;
  assign ferr = ~(s1_q & rxs);
  assign brk  = (data_q == 8'h00) & ~par_q & ~s1_q & ~rxs;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    s1_d    = s1_q;
    addr_d  = addr_q;
    odata_d = odata_q;
    count_d = count_q;

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        addr_d  = '0;
        count_d = '0;
        if (!en_n) state_d = StHunt;
      end
      StHunt: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rxs ? StHunt : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d  = '0;
          data_d = {rxs, data_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          s1_d    = rxs;
          state_d = StStop2;
        end
      end
      StStop2: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          odata_d = {brk, ferr, perr, par_q, data_q};
          state_d = StWrite;
        end
      end
      StWrite: begin
        cnt_d   = '0;
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W + 1)'(1);
        // A full memory wins over a break so no word can ever be written past the end.
        if (count_q == LastCount) state_d = StDone;
        else if (odata_q[11])     state_d = StBrkWait;
        else                      state_d = StHunt;
      end
      StBrkWait: begin
        cnt_d = '0;
        if (rxs) state_d = StHunt;
      end
      StDone: begin
        cnt_d  = '0;
        addr_d = '0;
      end
      default: state_d = StIdle;
    endcase

    if (en_n) begin
      state_d = StIdle;
      addr_d  = '0;
      count_d = '0;
    end
  end

  assign csb0_d = (state_d != StWrite);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      s1_q    <= 1'b0;
      csb0_q  <= 1'b1;
      addr_q  <= '0;
      odata_q <= '0;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      s1_q    <= s1_d;
      csb0_q  <= csb0_d;
      addr_q  <= addr_d;
      odata_q <= odata_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      StStart, StData, StParity, StStop1, StStop2, StWrite: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign full   = (state_q == StDone);
  assign csb0   = csb0_q;
  assign web0   = csb0_q;
  assign addr0  = addr_q;
  assign o_data = odata_q;
  assign count  = count_q;

endmodule

// File: tb/tb_updi_rx_framer.sv
// Randomised + directed bench for updi_rx_framer; expected memory writes come from a
// frame-level model queue and are checked on every write strobe.
module tb_updi_rx_framer;

  localparam int unsigned CPB    = 4;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned WORDS  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en_n = 1'b1;
  logic              rxd = 1'b1;
  logic              csb0, web0, busy, full;
  logic [ADDR_W-1:0] addr0;
  logic [11:0]       o_data;
  logic [ADDR_W:0]   count;

  int tests = 0;
  int failed = 0;
  int model_n = 0;
  logic [18:0] exp_q[$];

  updi_rx_framer #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .en_n(en_n), .rxd(rxd), .csb0(csb0), .web0(web0),
    .addr0(addr0), .o_data(o_data), .count(count), .busy(busy), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Status word from the frame-level rules: odd total ones -> perr, any low stop -> ferr,
  // everything low -> brk.
  function automatic logic [11:0] exp_word(input logic [7:0] d, input logic p, input logic s1,
                                           input logic s2);
    int ones;
    logic perr, ferr, brk;
    ones = $countones(d) + int'(p);
    perr = (ones % 2) == 1;
    ferr = !(s1 && s2);
    brk  = (d == 8'h00) && !p && !s1 && !s2;
    return {brk, ferr, perr, p, d};
  endfunction

  function automatic void expect_word(input logic [11:0] w);
    if (model_n < int'(WORDS)) begin
      exp_q.push_back({7'(model_n), w});
      model_n++;
    end
  endfunction

  // Every write strobe must match the next expected word, address and count.
  always @(negedge clk) begin
    if (csb0 === 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: got addr0=%0h o_data=%03h, expected no write",
                 addr0, o_data);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(addr0), 32'(e[18:12]));
        check("wr_data", 32'(o_data), 32'(e[11:0]));
        check("wr_web0", 32'(web0), 32'd0);
        check("wr_count", 32'(count), 32'(e[18:12]));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    wait_cyc(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2,
                            input logic [11:0] w);
    expect_word(w);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s1);
    drive_bit(s2);
    rxd = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      wait_cyc(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic reenable();
    en_n = 1'b1;
    rxd  = 1'b1;
    wait_cyc(3);
    en_n    = 1'b0;
    model_n = 0;
    wait_cyc(2 * CPB);
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s1, s2;
    int         gap;

    wait_cyc(3);
    check("rst_csb0", 32'(csb0), 32'd1);
    check("rst_web0", 32'(web0), 32'd1);
    check("rst_addr0", 32'(addr0), 32'd0);
    check("rst_o_data", 32'(o_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst = 1'b1;

    check("pin_model_055", 32'(exp_word(8'h55, 1'b0, 1'b1, 1'b1)), 32'h055);
    check("pin_model_207", 32'(exp_word(8'h07, 1'b0, 1'b1, 1'b1)), 32'h207);
    check("pin_model_107", 32'(exp_word(8'h07, 1'b1, 1'b1, 1'b1)), 32'h107);
    check("pin_model_c00", 32'(exp_word(8'h00, 1'b0, 1'b0, 1'b0)), 32'hC00);

    // Plain frame.
    reenable();
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 12'h055);
    wait_cyc(3 * CPB);
    drain("t1_drain");
    check("t1_count", 32'(count), 32'd1);

    // Parity error and correct parity.
    reenable();
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 12'h207);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 12'h107);
    wait_cyc(3 * CPB);
    drain("t2_drain");
    check("t2_count", 32'(count), 32'd2);

    // Long break gives a single word, then a normal frame follows at the next address.
    reenable();
    expect_word(12'hC00);
    rxd = 1'b0;
    wait_cyc(20 * CPB);
    rxd = 1'b1;
    wait_cyc(2 * CPB);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 12'h0A5);
    wait_cyc(3 * CPB);
    drain("t3_drain");
    check("t3_count", 32'(count), 32'd2);

    // One-cycle glitch is rejected.
    reenable();
    rxd = 1'b0;
    wait_cyc(1);
    rxd = 1'b1;
    wait_cyc(3 * CPB);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_count", 32'(count), 32'd0);
    drain("t4_drain");

    // Abort with en_n in data bit 4.
    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rxd = d[4];
    wait_cyc(2);
    check("t6a_busy_mid", 32'(busy), 32'd1);
    en_n = 1'b1;
    rxd  = 1'b1;
    wait_cyc(1);
    check("t6a_busy", 32'(busy), 32'd0);
    check("t6a_count", 32'(count), 32'd0);
    check("t6a_csb0", 32'(csb0), 32'd1);
    reenable();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 12'h03C);
    wait_cyc(3 * CPB);
    drain("t6a_drain");

    // Abort with reset in data bit 4.
    reenable();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rxd = d[4];
    wait_cyc(2);
    rst = 1'b0;
    rxd = 1'b1;
    wait_cyc(1);
    check("t6b_busy", 32'(busy), 32'd0);
    check("t6b_count", 32'(count), 32'd0);
    check("t6b_o_data", 32'(o_data), 32'd0);
    check("t6b_csb0", 32'(csb0), 32'd1);
    rst     = 1'b1;
    model_n = 0;
    wait_cyc(2 * CPB);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 12'h03C);
    wait_cyc(3 * CPB);
    drain("t6b_drain");

    // Random frames with random parity/stop errors and gaps.
    reenable();
    for (int k = 0; k < 40; k++) begin
      d  = 8'($urandom);
      p  = ($urandom_range(0, 3) != 0) ? ^d : 1'($urandom);
      s1 = 1'b1;
      s2 = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        s1 = 1'($urandom);
        s2 = 1'($urandom);
      end
      if (d == 8'h00 && !p && !s1 && !s2) s2 = 1'b1;
      send_frame(d, p, s1, s2, exp_word(d, p, s1, s2));
      gap = s2 ? $urandom_range(0, 2) : 2;
      wait_cyc(gap * CPB);
    end
    wait_cyc(3 * CPB);
    drain("rnd_drain");
    check("rnd_count", 32'(count), 32'd40);

    // Fill the memory back to back, then one more frame must be ignored.
    reenable();
    for (int k = 0; k < int'(WORDS); k++) begin
      d = 8'($urandom);
      send_frame(d, ^d, 1'b1, 1'b1, exp_word(d, ^d, 1'b1, 1'b1));
    end
    wait_cyc(3 * CPB);
    drain("t5_drain");
    check("t5_full", 32'(full), 32'd1);
    check("t5_addr0", 32'(addr0), 32'd0);
    check("t5_count", 32'(count), 32'(WORDS));
    check("t5_busy", 32'(busy), 32'd0);
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 12'h012);
    wait_cyc(3 * CPB);
    check("t5_full_hold", 32'(full), 32'd1);
    en_n = 1'b1;
    wait_cyc(1);
    check("t5_full_clr", 32'(full), 32'd0);
    check("t5_count_clr", 32'(count), 32'd0);
    check("t5_addr_clr", 32'(addr0), 32'd0);
    wait_cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
